// File: rtl/bus_read_monitor.sv
// bus_read_monitor: passive valid/ready read-bus monitor pairing requests with in-order responses; define BUS_MON_TRACE_EN for trace output and fatal stop on overflow/timeout
module bus_read_monitor #(
  parameter int addr_width      = 32,
  parameter int data_width      = 32,
  parameter int max_outstanding = 4,
  parameter int timeout_cycles  = 256
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 addr_valid,
  input  logic                                 addr_ready,
  input  logic [addr_width-1:0]                addr,
  input  logic                                 data_valid,
  input  logic                                 data_ready,
  input  logic [data_width-1:0]                data,
  output logic                                 txn_valid,
  output logic [addr_width-1:0]                txn_addr,
  output logic [data_width-1:0]                txn_data,
  output logic [15:0]                          txn_latency,
  output logic                                 err_valid,
  output logic [2:0]                           err_code,
  output logic [$clog2(max_outstanding):0]     outstanding
);
  localparam int pw = $clog2(max_outstanding);
  localparam int ow = pw + 1;
  logic [addr_width-1:0] r_q_addr [max_outstanding];
  logic [15:0]           r_q_ts   [max_outstanding];
  logic [pw-1:0]         r_head, r_tail;
  logic [ow-1:0]         r_occ;
  logic [15:0]           r_cnt;
  logic                  r_hist, r_pav, r_par, r_pdv, r_pdr, r_to;
  logic [addr_width-1:0] r_pa;
  logic [data_width-1:0] r_pd;
  logic                  w_push_hs, w_rsp_hs, w_empty, w_pop, w_ovf, w_push;
  logic [15:0]           w_age;
  logic [7:1]            w_err;
  logic [2:0]            w_code;
  assign w_push_hs = addr_valid & addr_ready;
  assign w_rsp_hs  = data_valid & data_ready;
  assign w_empty   = r_occ == '0;
  assign w_pop     = w_rsp_hs & ~w_empty;
  assign w_ovf     = w_push_hs & (r_occ == ow'(max_outstanding)) & ~w_pop;
  assign w_push    = w_push_hs & ~w_ovf;
  assign w_age     = r_cnt - r_q_ts[r_head];
  assign w_err[1]  = r_hist & r_pav & ~r_par & ~addr_valid;
  assign w_err[2]  = r_hist & r_pav & ~r_par & addr_valid & (addr != r_pa);
  assign w_err[3]  = r_hist & r_pdv & ~r_pdr & ~data_valid;
  assign w_err[4]  = r_hist & r_pdv & ~r_pdr & data_valid & (data != r_pd);
  assign w_err[5]  = w_rsp_hs & w_empty;
  assign w_err[6]  = w_ovf;
  assign w_err[7]  = ~w_empty & ~r_to & (w_age >= 16'(timeout_cycles));
  assign outstanding = r_occ;
  always_comb
    w_code = w_err[1] ? 3'd1 : w_err[2] ? 3'd2 : w_err[3] ? 3'd3 : w_err[4] ? 3'd4 :
             w_err[5] ? 3'd5 : w_err[6] ? 3'd6 : 3'd7;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_occ       <= '0;
      r_cnt       <= '0;
      r_hist      <= 1'b0;
      r_pav       <= 1'b0;
      r_par       <= 1'b0;
      r_pdv       <= 1'b0;
      r_pdr       <= 1'b0;
      r_pa        <= '0;
      r_pd        <= '0;
      r_to        <= 1'b0;
      txn_valid   <= 1'b0;
      txn_addr    <= '0;
      txn_data    <= '0;
      txn_latency <= '0;
      err_valid   <= 1'b0;
      err_code    <= '0;
    end else begin
      r_cnt  <= r_cnt + 16'd1;
      r_hist <= 1'b1;
      r_pav  <= addr_valid;
      r_par  <= addr_ready;
      r_pa   <= addr;
      r_pdv  <= data_valid;
      r_pdr  <= data_ready;
      r_pd   <= data;
      if (w_push) begin
        r_q_addr[r_tail] <= addr;
        r_q_ts[r_tail]   <= r_cnt;
        r_tail           <= r_tail + pw'(1);
      end
      if (w_pop) r_head <= r_head + pw'(1);
      r_occ     <= r_occ + ow'(w_push) - ow'(w_pop);
      // timeout flag belongs to the current head; a pop hands over a fresh head
      r_to      <= w_pop ? 1'b0 : r_to | w_err[7];
      txn_valid <= w_pop;
      if (w_pop) begin
        txn_addr    <= r_q_addr[r_head];
        txn_data    <= data;
        txn_latency <= w_age;
      end
      err_valid <= |w_err;
      if (|w_err) err_code <= w_code;
    end
  end
`ifdef BUS_MON_TRACE_EN
  function automatic string err_name(input logic [2:0] c);
    return c == 3'd1 ? "ADDR_DROP" : c == 3'd2 ? "ADDR_UNSTABLE" : c == 3'd3 ? "DATA_DROP" :
           c == 3'd4 ? "DATA_UNSTABLE" : c == 3'd5 ? "ORPHAN_RSP" : c == 3'd6 ? "OVERFLOW" : "TIMEOUT";
  endfunction
  always_ff @(posedge clk) begin
    if (txn_valid) $display("%0t txn addr=%0h data=%0h latency=%0d", $time, txn_addr, txn_data, txn_latency);
    if (err_valid) begin
      $display("%0t error %s", $time, err_name(err_code));
      if (err_code == 3'd6 || err_code == 3'd7) $fatal(1, "bus_read_monitor: %s", err_name(err_code));
    end
  end
`else
`endif
endmodule

// File: doc/bus_read_monitor.md
Name: bus_read_monitor

Overview:
- Passive monitor on one CPU valid/ready read bus (instruction or data read): address channel plus response channel.
- Pairs each address handshake with its in-order response and emits one transaction record per completed read.
- Detects protocol violations and reports them as coded error pulses.
- Sits between the CPU bus and the CPU checker, which consumes its transaction and error outputs for assertions and scoreboarding.

Parameters:
- addr_width, 32, address bus width.
- data_width, 32, response data width (instruction width).
- max_outstanding, 4, depth of the outstanding-request queue; power of two, at least 2.
- timeout_cycles, 256, maximum age of the oldest outstanding request before a timeout error; at most 65535.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-low reset.
- addr_valid  input  1  address channel valid.
- addr_ready  input  1  address channel ready.
- addr  input  addr_width  address payload.
- data_valid  input  1  response channel valid.
- data_ready  input  1  response channel ready.
- data  input  data_width  response payload.
- txn_valid  output  1  one-cycle pulse: completed transaction.
- txn_addr  output  addr_width  address of the completed transaction.
- txn_data  output  data_width  data of the completed transaction.
- txn_latency  output  16  cycles from address handshake to response handshake.
- err_valid  output  1  one-cycle pulse: violation detected.
- err_code  output  3  code of the last reported error; held until the next error.
- outstanding  output  $clog2(max_outstanding)+1  current queue occupancy.

Behaviour:
- Reset: while rst=0 at posedge, all outputs go to 0, the queue empties, the 16-bit free-running cycle counter clears, stability history clears, and no errors are reported. Reset mid-operation discards outstanding requests silently.
- Handshake definitions:
  - Address handshake: addr_valid & addr_ready at a posedge. Pushes {addr, cycle counter} to the queue tail.
  - Response handshake: data_valid & data_ready at a posedge. Pops the queue head.
- Transaction output:
  - Registered; txn_valid pulses in the cycle after the response handshake.
  - txn_addr = head address; txn_data = data.
  - txn_latency = counter − head timestamp, mod 2^16. A response one cycle after its request reports 1.
- Simultaneous push and pop: the pop is evaluated first against the pre-push occupancy, so occupancy is unchanged. With an empty queue, a same-cycle response is an orphan error, and the push is still accepted.
- Error codes, all pulsed one cycle after detection:
  - 1 ADDR_DROP: addr_valid was 1 without ready in the previous cycle and is 0 now.
  - 2 ADDR_UNSTABLE: addr_valid & !addr_ready in the previous cycle, addr_valid still 1, and addr differs from the previous value.
  - 3 DATA_DROP: the same rule as 1, for the response channel.
  - 4 DATA_UNSTABLE: the same rule as 2, for data.
  - 5 ORPHAN_RSP: response handshake while occupancy (pre-push) is 0. Nothing is popped and no txn is produced.
  - 6 OVERFLOW: push while occupancy = max_outstanding and no pop in the same cycle. The push is dropped.
  - 7 TIMEOUT: the head entry's age reaches timeout_cycles. Reported once per head entry, tracked by a per-head flag that clears on pop.
- Several errors in one cycle: the lowest code is reported. Others in that cycle are not reported.
- Stability history (previous valid/ready/payload) is invalid in the first cycle after reset; no drop or unstable checks run in that cycle.
- Counter wrap from 0xFFFF to 0 is legal; latency stays correct by modular subtraction.

Optional Feature:
- Macro BUS_MON_TRACE_EN.
- Defined: each txn_valid pulse $displays time, address, data and latency; each err_valid pulse $displays time and error name. The fatal path calls $fatal when err_code is 6 or 7.
- Undefined: no display or system tasks are compiled; behaviour is otherwise identical.

Test Plan:
- Single read: request addr 0x100 at cycle 10, response 0xDEADBEEF at cycle 13 → txn_valid at cycle 14, txn_addr 0x100, txn_data 0xDEADBEEF, txn_latency 3, no error.
- Pipelined: 4 back-to-back requests 0x0/0x4/0x8/0xC, then 4 responses → 4 in-order txns, outstanding peaks at 4. A 5th request before any response → err_code 6 and outstanding stays 4.
- Stability: addr_valid=1, ready=0, addr changes 0x20→0x24 → err_code 2. Separately, addr_valid deasserts before ready → err_code 1. The same two checks on the response channel → codes 4 and 3.
- Orphan and simultaneous: response with an empty queue → err_code 5 and no txn. Push and pop in the same cycle with occupancy 1 → txn produced, outstanding remains 1.
- Timeout and wrap: timeout_cycles=8, request with no response → single err_code 7 eight cycles after the request, not repeated. Request issued at counter 0xFFFE, response at 0x0001 → txn_latency 3.
- Reset mid-operation: 2 outstanding requests, rst=0 for one cycle → outstanding 0, no txn or error. A subsequent response → err_code 5.
